// File: rtl/rx_anc_pkg.sv
// rtl/rx_anc_pkg.sv - shared types and constants for the RX ANC hop sequencer
package rx_anc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RESET,
    GAP,
    RUN,
    DONE
  } state_t;

  localparam logic [7:0] ADDR_SCALE    = 8'h00;
  localparam logic [7:0] ADDR_NSAMP    = 8'h01;
  localparam logic [7:0] ADDR_NHOPS    = 8'h02;
  localparam logic [7:0] ADDR_LOOP     = 8'h03;
  localparam logic [7:0] ADDR_HOP_BASE = 8'h10;

  localparam int HOP_TABLE_LOG2  = 4;
  localparam int HOP_TABLE_DEPTH = 1 << HOP_TABLE_LOG2;

endpackage

// File: rtl/rx_anc_hop_seq_if.sv
// rtl/rx_anc_hop_seq_if.sv - settings bus and sample stream bundle for the hop sequencer
interface rx_anc_hop_seq_if;

  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;

  logic        s_tvalid;
  logic        s_tready;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;

  modport master (
    output set_stb, set_addr, set_data, s_tvalid, m_tready,
    input  s_tready, m_tvalid, m_tlast
  );

  modport slave (
    input  set_stb, set_addr, set_data, s_tvalid, m_tready,
    output s_tready, m_tvalid, m_tlast
  );

endinterface

// File: rtl/rx_anc_hop_table.sv
// rtl/rx_anc_hop_table.sv - phase increment table, one write port, one registered read port
module rx_anc_hop_table #(
  parameter int PHASE_WIDTH = 24,
  parameter int NHOP_LOG2   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [NHOP_LOG2-1:0]   wr_addr,
  input  logic [PHASE_WIDTH-1:0] wr_data,
  input  logic                   rd_en,
  input  logic [NHOP_LOG2-1:0]   rd_addr,
  output logic [PHASE_WIDTH-1:0] rd_data
);

  logic [PHASE_WIDTH-1:0] mem [1 << NHOP_LOG2];

  // Table contents are not reset; only the settings bus fills them
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register doubles as the held phase increment; it only moves when rd_en is high
  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rx_anc_hop_seq.sv
// rtl/rx_anc_hop_seq.sv - symbol/hop sequencer; RX_ANC_HOP_SEQ_STATUS_EN adds status counters
module rx_anc_hop_seq
  import rx_anc_pkg::*;
#(
  parameter int PHASE_WIDTH = 24,
  parameter int DATA_WIDTH  = 16,
  parameter int NSAMP_WIDTH = 16,
  parameter int NHOP_LOG2   = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  rx_anc_hop_seq_if.slave        bus,
  input  logic                   start,
  input  logic                   abort,
  output logic [PHASE_WIDTH-1:0] ppm_val,
  output logic [DATA_WIDTH-1:0]  scale_val,
  output logic                   srst,
  output logic [NHOP_LOG2-1:0]   hop_idx,
  output logic                   busy,
  output logic                   done
`ifdef RX_ANC_HOP_SEQ_STATUS_EN
  ,
  output logic [31:0]            stat_symbols,
  output logic                   stat_stall
`endif
);

  localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 2);

  state_t                 state, state_next;
  logic [NHOP_LOG2-1:0]   hop_next;
  logic [DATA_WIDTH-1:0]  scale_reg;
  logic [NSAMP_WIDTH-1:0] nsamp_reg, run_nsamp, samp_cnt;
  logic [NHOP_LOG2-1:0]   nhops_m1_reg, run_nhops_m1;
  logic                   loop_reg;
  logic [GAP_W-1:0]       gap_cnt;
  logic                   abort_d;
  logic                   beat, last_beat, start_ok;
  logic [7:0]             hop_off;
  logic                   hop_wr;
  logic                   unused_set_bits;

  assign hop_off = bus.set_addr - ADDR_HOP_BASE;
  assign hop_wr  = bus.set_stb && (bus.set_addr >= ADDR_HOP_BASE) &&
                   ({1'b0, hop_off} < 9'(1 << NHOP_LOG2));
  assign unused_set_bits = ^bus.set_data;

  assign beat      = (state == RUN) && bus.s_tvalid && bus.m_tready;
  assign last_beat = beat && (samp_cnt == run_nsamp - NSAMP_WIDTH'(1));
  assign start_ok  = (state == IDLE) && start && !abort;

  rx_anc_hop_table #(
    .PHASE_WIDTH (PHASE_WIDTH),
    .NHOP_LOG2   (NHOP_LOG2)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (hop_wr),
    .wr_addr (hop_off[NHOP_LOG2-1:0]),
    .wr_data (bus.set_data[PHASE_WIDTH-1:0]),
    .rd_en   (state == LOAD),
    .rd_addr (hop_idx),
    .rd_data (ppm_val)
  );

  // Settings registers; a zero sample count is stored as one so a symbol is never empty
  always_ff @(posedge clk) begin
    if (reset) begin
      scale_reg    <= DATA_WIDTH'(1);
      nsamp_reg    <= NSAMP_WIDTH'(1);
      nhops_m1_reg <= '0;
      loop_reg     <= 1'b0;
    end else if (bus.set_stb) begin
      case (bus.set_addr)
        ADDR_SCALE: scale_reg    <= bus.set_data[DATA_WIDTH-1:0];
        ADDR_NSAMP: nsamp_reg    <= (bus.set_data[NSAMP_WIDTH-1:0] == '0) ?
                                    NSAMP_WIDTH'(1) : bus.set_data[NSAMP_WIDTH-1:0];
        ADDR_NHOPS: nhops_m1_reg <= bus.set_data[NHOP_LOG2-1:0];
        ADDR_LOOP:  loop_reg     <= bus.set_data[0];
        default:    ;
      endcase
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, next hop and stream gating; abort overrides everything
  always_comb begin
    state_next   = state;
    hop_next     = hop_idx;
    bus.m_tvalid = 1'b0;
    bus.s_tready = 1'b0;
    bus.m_tlast  = 1'b0;
    srst         = (state == RESET) || abort_d;
    busy         = (state != IDLE);
    done         = (state == DONE);
    case (state)
      IDLE: if (start) begin
        state_next = LOAD;
        hop_next   = '0;
      end
      LOAD:  state_next = RESET;
      RESET: state_next = GAP;
      GAP:   if (gap_cnt == GAP_LAST) state_next = RUN;
      RUN: begin
        bus.m_tvalid = bus.s_tvalid;
        bus.s_tready = bus.m_tready;
        bus.m_tlast  = (samp_cnt == run_nsamp - NSAMP_WIDTH'(1));
        if (last_beat) begin
          if (hop_idx >= run_nhops_m1) begin
            if (loop_reg) begin
              hop_next   = '0;
              state_next = LOAD;
            end else begin
              state_next = DONE;
            end
          end else begin
            hop_next   = hop_idx + NHOP_LOG2'(1);
            state_next = LOAD;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      hop_next   = '0;
    end
  end

  // Per-symbol counters and per-run snapshots of the settings
  always_ff @(posedge clk) begin
    if (reset) begin
      hop_idx      <= '0;
      samp_cnt     <= '0;
      gap_cnt      <= '0;
      run_nsamp    <= NSAMP_WIDTH'(1);
      run_nhops_m1 <= '0;
      scale_val    <= '0;
      abort_d      <= 1'b0;
    end else begin
      abort_d <= abort;
      hop_idx <= hop_next;
      if (start_ok) scale_val <= scale_reg;
      if (state == LOAD) begin
        samp_cnt     <= '0;
        run_nsamp    <= nsamp_reg;
        run_nhops_m1 <= nhops_m1_reg;
      end else if (beat) begin
        samp_cnt <= samp_cnt + NSAMP_WIDTH'(1);
      end
      if (state == RESET)    gap_cnt <= '0;
      else if (state == GAP) gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end

`ifdef RX_ANC_HOP_SEQ_STATUS_EN
  logic [NSAMP_WIDTH:0] stall_cnt;

  // Completed-symbol count and sticky stall flag, both cleared by an accepted start
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      stat_symbols <= '0;
      stat_stall   <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      if (last_beat && stat_symbols != '1) stat_symbols <= stat_symbols + 32'd1;
      if (state == RUN && !bus.s_tvalid) begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        if (stall_cnt >= {1'b0, run_nsamp}) stat_stall <= 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end
`endif

endmodule
